serial_adder: RTL and testbench

- Bit-serial N-bit adder built around one full-adder bit-slice (the team's FA module) and a carry flip-flop.
- Accepts two parallel operands and a carry-in on a start pulse.
- Feeds the slice LSB-first, one bit per clock, and shifts the slice's sum bits into a result register.
- Trades latency for area; sits in the datapath wherever a wide ripple adder is too large.

---
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built from one full-adder slice and a
// carry flop. Operands are captured on an accepted start, processed LSB-first
// one bit per clock, and the result appears N cycles after the start edge.
//
// Handshake: start is sampled only while the block is accepting (IDLE or
// DONE). busy is high for exactly the N processing cycles. done is a single
// cycle pulse, and sum_out/cout (and ovf) are valid from that cycle until the
// next accepted start completes.
//
// Optional build macro SERIAL_ADDER_OVF_EN adds the ovf output, the signed
// two's-complement overflow of the last result.

// One-bit full adder slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum_out,
  output logic         cout,
  output logic [1:0]   dbg_state
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-2:0]   res;       // sum bits collected so far (the newest bit is not yet stored)
  logic [N-1:0]   shifted;   // result register after this cycle's bit is shifted in
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           slice_sum;
  logic           slice_cout;
  logic           accept;
  logic           last_bit;

  full_adder u_slice (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (slice_sum),
    .co (slice_cout)
  );

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_bit  = (state == SHIFT) && (cnt == CW'(N - 1));
  assign shifted   = {slice_sum, res};
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a start in DONE re-enters SHIFT with no idle gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shift/add and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept) begin
        a_sr  <= a_in;
        b_sr  <= b_in;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        res   <= shifted[N-1:1];
        carry <= slice_cout;
        cnt   <= cnt + CW'(1);
        if (last_bit) begin
          sum_out <= shifted;
          cout    <= slice_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB slice during the last bit
          ovf     <= carry ^ slice_cout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (N=8): directed vector table, hand-written
// sequences for start-while-busy, reset mid-operation and back-to-back
// operation, then randomized operations checked against an arithmetic model.
module tb_serial_adder;

  localparam int N = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum_out;
  logic         cout;
  logic [1:0]   dbg_state;
  logic         ovf_s;

  int errors = 0;
  int checks = 0;

  // expected {ovf, cout, sum} per issued operation
  logic [N+1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N-1:0] sum;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  serial_adder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .cout      (cout),
    .dbg_state (dbg_state)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf_s)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf_s = 1'b0;
`endif

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: plain unsigned and signed arithmetic
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    int ua, ub, sa, sb, s;
    logic [N:0] u;
    logic ov;
    ua = int'(a);
    ub = int'(b);
    u  = (N+1)'(ua + ub + int'(c));
    sa = (ua >= 2**(N-1)) ? ua - 2**N : ua;
    sb = (ub >= 2**(N-1)) ? ub - 2**N : ub;
    s  = sa + sb + int'(c);
    ov = (s > 2**(N-1) - 1) || (s < -(2**(N-1)));
    return {ov, u};
  endfunction

  // compare the outputs on a done cycle against the scoreboard head
  task automatic score(input string name);
    logic [N+1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got done with empty queue, required no done", name);
    end else begin
      checks--;
      e = exp_q.pop_front();
      chk({name, "_sum"}, 32'(sum_out), 32'(e[N-1:0]));
      chk({name, "_cout"}, 32'(cout), 32'(e[N]));
`ifdef SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"}, 32'(ovf_s), 32'(e[N+1]));
`endif
    end
  endtask

  // one full operation; glitch >= 0 pulses start with junk operands on that SHIFT cycle
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input int glitch, output logic [N-1:0] s_o, output logic co_o,
                        output logic ov_o);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    exp_q.push_back(model(a, b, c));
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (i == glitch) begin
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        cin   = 1'b1;
      end else begin
        start = 1'b0;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
        cin   = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    s_o  = sum_out;
    co_o = cout;
    ov_o = ovf_s;
    if (done) score("op");
    @(negedge clk);
    chk("done_after", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum_out), 32'(s_o));
  endtask

  initial begin
    logic [N-1:0] s;
    logic         co;
    logic         ov;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           g;

    vecs[0] = '{8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    // reset
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf_s), 32'd0);
`endif
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, -1, s, co, ov);
      chk("vec_sum", 32'(s), 32'(vecs[i].sum));
      chk("vec_cout", 32'(co), 32'(vecs[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk("vec_ovf", 32'(ov), 32'(vecs[i].ov));
`endif
    end

    // start pulsed on cycle 3 of SHIFT is ignored
    run_op(8'h3C, 8'h15, 1'b0, 2, s, co, ov);
    chk("ign_sum", 32'(s), 32'h51);
    chk("ign_cout", 32'(co), 32'd0);
    repeat (N + 2) begin
      @(negedge clk);
      chk("ign_no_done", 32'(done), 32'd0);
    end

    // reset during SHIFT discards the operation
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_state", 32'(dbg_state), 32'(ST_SHIFT));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum_out), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (N + 2) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done), 32'd0);
    end
    run_op(8'h3C, 8'h15, 1'b0, -1, s, co, ov);
    chk("post_rst_sum", 32'(s), 32'h51);

    // back-to-back: start held high across DONE
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h15; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h3C, 8'h15, 1'b0));
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("b2b_busy1", 32'(busy), 32'd1);
      if (i == N - 1) begin
        start = 1'b1; a_in = 8'h01; b_in = 8'h02; cin = 1'b0;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_sum1", 32'(sum_out), 32'h51);
    if (done) score("b2b1");
    @(negedge clk);
    start = 1'b0;
    chk("b2b_nogap_busy", 32'(busy), 32'd1);
    chk("b2b_nogap_done", 32'(done), 32'd0);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      chk("b2b_busy2", 32'(busy), 32'd1);
      chk("b2b_done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_sum2", 32'(sum_out), 32'h03);
    chk("b2b_cout2", 32'(cout), 32'd0);
    if (done) score("b2b2");
    @(negedge clk);
    chk("b2b_done_after", 32'(done), 32'd0);

    // randomized operations against the model
    for (int k = 0; k < 40; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      g  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 2) : -1;
      run_op(ra, rb, 1'($urandom), g, s, co, ov);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
